// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath: sequences fetch, decode,
// memory, ALU, branch/jump and interrupt-entry steps and decodes the datapath strobes.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       interrupt,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       irWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic       epcWrite,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        RTEXEC   = 4'd6,
        RTWB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11,
        INTR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;
    state_t end_state;
    logic   int_q;
    logic   int_pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A new edge arriving in the INTR cycle must not be lost, so set beats clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_q       <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            int_q <= interrupt;
            if (interrupt && !int_q) begin
                int_pending <= 1'b1;
            end else if (state_q == INTR) begin
                int_pending <= 1'b0;
            end
        end
    end

    assign end_state = int_pending ? INTR : FETCH;
    assign state     = state_q;

    always_comb begin
        state_d     = FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        epcWrite    = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                // Gate the write strobes with reset so nothing is latched while held in reset.
                irWrite = mem_ready & reset;
                pcWrite = mem_ready & reset;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = RTEXEC;
                    OP_LW, OP_SW: state_d = MEMADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = end_state;
                    end
                endcase
            end
            MEMADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
                state_d  = end_state;
            end
            MEMWRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                state_d  = mem_ready ? end_state : MEMWRITE;
            end
            RTEXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = RTWB;
            end
            RTWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                state_d  = end_state;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcWrite     = zero;
                pcSource    = 2'b01;
                state_d     = end_state;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                state_d  = end_state;
            end
            ADDIEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regWrite = 1'b1;
                state_d  = end_state;
            end
            INTR: begin
                epcWrite = 1'b1;
                pcWrite  = 1'b1;
                pcSource = 2'b11;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule
